// File: rtl/serial_send_if.sv
`default_nettype none
// ============================================================================
//  Module      : serial_send_if
//  Description : Word handshake between a data source and serial_send.
//                The source presents DIN/DIN_VALID; the transmitter raises
//                DIN_READY in its load cycle. Transfer = VALID & READY.
//  Revision    : 1.0  initial release
// ============================================================================
interface serial_send_if;
    logic [63:0] DIN;
    logic        DIN_VALID;
    logic        DIN_READY;

    modport master (
        output DIN,
        output DIN_VALID,
        input  DIN_READY
    );

    modport slave (
        input  DIN,
        input  DIN_VALID,
        output DIN_READY
    );
endinterface
`default_nettype wire

// File: rtl/serial_send.sv
`default_nettype none
// ============================================================================
//  Module      : serial_send
//  Description : LVDS DDR serial transmitter. Serializes 64-bit words two bits
//                per CLKS cycle, emits a 1/32-rate FRAME clock whose falling
//                edge marks word boundaries, and offers a PRBS-31 mode with
//                single-bit error injection for BER runs.
//  Revision    : 1.0  initial release
// ============================================================================
module serial_send #(
    parameter logic [63:0] IDLE_WORD = 64'hA5A5_5A5A_0F0F_F0F0,
    parameter logic [30:0] PRBS_SEED = 31'h0000_0001
) (
    input  wire logic        CLKS,
    input  wire logic        RSTXS,
    input  wire logic        MODE,
    input  wire logic        ERR_INJ,
    serial_send_if.slave     din_if,
    output      logic        FRAME,
    output      logic [31:0] WORD_CNT,
    output      logic [1:0]  DOUT
);

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [30:0] c_seed     = (PRBS_SEED == 31'd0) ? 31'd1 : PRBS_SEED;
    localparam logic [4:0]  c_load_cnt = 5'd31;
    localparam logic [4:0]  c_frame_hi = 5'd15;
    localparam logic [4:0]  c_frame_lo = 5'd30;

    logic [4:0]  cnt_q,      cnt_d;
    logic [63:0] shift_q,    shift_d;
    logic [30:0] lfsr_q,     lfsr_d;
    logic        err_pend_q, err_pend_d;
    logic        frame_q,    frame_d;
    logic [31:0] word_cnt_q, word_cnt_d;
    logic        d0_q,       d1_q;

    logic        w_load;
    logic        w_err_now;
    logic [63:0] w_prbs_word;
    logic [30:0] w_lfsr_adv;
    logic        w_new_bit;
    logic [63:0] w_next_word;
    logic        w_pad_p;

    // Run the LFSR 64 steps ahead; the first generated bit lands in bit 63.
    always_comb begin
        w_lfsr_adv  = lfsr_q;
        w_prbs_word = 64'd0;
        w_new_bit   = 1'b0;
        for (int i = 0; i < 64; i++) begin
            w_new_bit          = w_lfsr_adv[30] ^ w_lfsr_adv[27];
            w_prbs_word[63-i]  = w_new_bit;
            w_lfsr_adv         = {w_lfsr_adv[29:0], w_new_bit};
        end
    end

    // Next-state logic for counter, shifter, LFSR, error flag and frame clock.
    always_comb begin
        w_load           = (cnt_q == c_load_cnt);
        w_err_now        = err_pend_q | ERR_INJ;
        din_if.DIN_READY = w_load & ~MODE;

        if (MODE)
            w_next_word = w_prbs_word;
        else if (din_if.DIN_VALID)
            w_next_word = din_if.DIN;
        else
            w_next_word = IDLE_WORD;

        cnt_d = cnt_q + 5'd1;

        // Frame is high for cnt 16..31 of the register, so it falls on the
        // same edge that loads a new word into the shifter.
        frame_d = (cnt_q >= c_frame_hi) && (cnt_q <= c_frame_lo);

        if (w_load) begin
            shift_d    = w_next_word ^ {w_err_now, 63'd0};
            err_pend_d = 1'b0;
            word_cnt_d = word_cnt_q + 32'd1;
            lfsr_d     = MODE ? w_lfsr_adv : lfsr_q;
        end else begin
            shift_d    = {shift_q[61:0], 2'b00};
            err_pend_d = w_err_now;
            word_cnt_d = word_cnt_q;
            lfsr_d     = lfsr_q;
        end
    end

    // Core state registers.
    always_ff @(posedge CLKS or negedge RSTXS) begin
        if (!RSTXS) begin
            cnt_q      <= 5'd0;
            shift_q    <= 64'd0;
            lfsr_q     <= c_seed;
            err_pend_q <= 1'b0;
            frame_q    <= 1'b0;
            word_cnt_q <= 32'd0;
        end else begin
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            lfsr_q     <= lfsr_d;
            err_pend_q <= err_pend_d;
            frame_q    <= frame_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    // DDR output stage: both halves captured on the rising edge (C0-aligned),
    // reset to zero so the pad idles low while RSTXS is asserted.
    always_ff @(posedge CLKS or negedge RSTXS) begin
        if (!RSTXS) begin
            d0_q <= 1'b0;
            d1_q <= 1'b0;
        end else begin
            d0_q <= shift_q[63];
            d1_q <= shift_q[62];
        end
    end

    // Rising half drives D0, falling half D1; the buffer provides P and N.
    always_comb begin
        w_pad_p = CLKS ? d0_q : d1_q;
        DOUT    = {~w_pad_p, w_pad_p};
    end

    assign FRAME    = frame_q;
    assign WORD_CNT = word_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_send.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_send
//  Description : Directed self-checking bench for serial_send.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_serial_send;

    localparam logic [63:0] c_idle = 64'hA5A5_5A5A_0F0F_F0F0;
    localparam logic [63:0] c_din  = 64'h0123_4567_89AB_CDEF;
    localparam logic [30:0] c_seed = 31'h0000_0001;

    logic        CLKS;
    logic        RSTXS;
    logic        MODE;
    logic        ERR_INJ;
    logic        FRAME;
    logic [31:0] WORD_CNT;
    logic [1:0]  DOUT;

    serial_send_if sif();

    serial_send #(
        .IDLE_WORD (c_idle),
        .PRBS_SEED (c_seed)
    ) dut (
        .CLKS     (CLKS),
        .RSTXS    (RSTXS),
        .MODE     (MODE),
        .ERR_INJ  (ERR_INJ),
        .din_if   (sif),
        .FRAME    (FRAME),
        .WORD_CNT (WORD_CNT),
        .DOUT     (DOUT)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference PRBS-31 stream: s[k] = s[k-31] ^ s[k-28], index offset by 31
    logic prbs_s [0:31+64*3];

    initial begin
        CLKS = 1'b0;
        forever #5 CLKS = ~CLKS;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] prbs_word(input int j);
        logic [63:0] w;
        for (int i = 0; i < 64; i++)
            w[63-i] = prbs_s[31 + 64*j + i];
        return w;
    endfunction

    // Capture one word from the pad. Call just after a load edge. Optionally
    // pulse ERR_INJ at two cnt values and change MODE at one cnt value.
    task automatic capture(input int err_a, input int err_b, input int mode_at,
                           input logic mode_val, output logic [63:0] w, output int rdy);
        int cur;
        rdy = 0;
        w   = 64'd0;
        for (int k = 1; k <= 32; k++) begin
            @(posedge CLKS); #1;
            w[65-2*k] = DOUT[0];
            if (sif.DIN_READY) rdy++;
            cur     = k % 32;
            ERR_INJ = (cur == err_a) || (cur == err_b);
            if (cur == mode_at) MODE = mode_val;
            @(negedge CLKS); #1;
            w[64-2*k] = DOUT[0];
        end
        ERR_INJ = 1'b0;
    endtask

    logic [63:0] w;
    int          rdy;

    initial begin
        for (int i = 0; i < 31; i++) prbs_s[30-i] = c_seed[i];
        for (int k = 0; k < 64*3; k++) prbs_s[k+31] = prbs_s[k] ^ prbs_s[k+3];

        RSTXS         = 1'b0;
        MODE          = 1'b0;
        ERR_INJ       = 1'b0;
        sif.DIN       = 64'd0;
        sif.DIN_VALID = 1'b0;

        // Reset state
        repeat (3) @(posedge CLKS);
        #1;
        chk("rst_frame", {63'd0, FRAME}, 64'd0);
        chk("rst_ready", {63'd0, sif.DIN_READY}, 64'd0);
        chk("rst_wcnt",  {32'd0, WORD_CNT}, 64'd0);
        chk("rst_dout",  {62'd0, DOUT}, 64'd2);

        // Scenario 1: release, idle words, first load 31 cycles after first edge
        @(negedge CLKS);
        RSTXS = 1'b1;
        repeat (31) @(posedge CLKS);
        #1;
        chk("s1_frame_pre", {63'd0, FRAME}, 64'd1);
        chk("s1_ready_pre", {63'd0, sif.DIN_READY}, 64'd1);
        chk("s1_wcnt_pre",  {32'd0, WORD_CNT}, 64'd0);
        @(posedge CLKS); #1;
        chk("s1_frame_fall", {63'd0, FRAME}, 64'd0);
        chk("s1_wcnt_1",     {32'd0, WORD_CNT}, 64'd1);
        chk("s1_dout_diff",  {62'd0, DOUT}, {62'd0, ~DOUT[0], DOUT[0]});
        capture(-1, -1, -1, 1'b0, w, rdy);
        chk("s1_idle_w1", w, c_idle);
        chk("s1_rdy_w1",  64'(rdy), 64'd1);
        chk("s1_wcnt_2",  {32'd0, WORD_CNT}, 64'd2);

        // Scenario 2: user word held valid
        sif.DIN       = c_din;
        sif.DIN_VALID = 1'b1;
        capture(-1, -1, -1, 1'b0, w, rdy);
        chk("s2_idle_w2", w, c_idle);
        chk("s2_wcnt_3",  {32'd0, WORD_CNT}, 64'd3);

        // Scenario 4: two ERR_INJ pulses in one frame give one flip next word
        capture(5, 20, -1, 1'b0, w, rdy);
        chk("s2_data_w3", w, c_din);
        chk("s2_rdy_w3",  64'(rdy), 64'd1);
        capture(-1, -1, -1, 1'b0, w, rdy);
        chk("s4_err_w4",  w, c_din ^ 64'h8000_0000_0000_0000);

        // Scenario 5: MODE 0->1 mid-frame
        capture(-1, -1, 10, 1'b1, w, rdy);
        chk("s4_clean_w5", w, c_din);
        chk("s5_rdy_w5",   64'(rdy), 64'd0);

        // Scenario 3: PRBS words, pause 3 frames, resume
        capture(-1, -1, -1, 1'b0, w, rdy);
        chk("s3_prbs0",   w, prbs_word(0));
        chk("s5_rdy_w6",  64'(rdy), 64'd0);
        capture(-1, -1, 10, 1'b0, w, rdy);
        chk("s3_prbs1",   w, prbs_word(1));
        chk("s3_rdy_w7",  64'(rdy), 64'd1);
        capture(-1, -1, -1, 1'b0, w, rdy);
        chk("s3_data_w8", w, c_din);
        capture(-1, -1, -1, 1'b0, w, rdy);
        chk("s3_data_w9", w, c_din);
        capture(-1, -1, 10, 1'b1, w, rdy);
        chk("s3_data_w10", w, c_din);
        capture(-1, -1, -1, 1'b0, w, rdy);
        chk("s3_prbs2",    w, prbs_word(2));
        chk("s3_wcnt_12",  {32'd0, WORD_CNT}, 64'd12);

        // Scenario 6: reset at cnt=17 for 3 cycles, LFSR reseeded
        repeat (17) @(posedge CLKS);
        #1;
        chk("s6_frame_hi", {63'd0, FRAME}, 64'd1);
        RSTXS = 1'b0;
        #1;
        chk("s6_rst_frame", {63'd0, FRAME}, 64'd0);
        chk("s6_rst_wcnt",  {32'd0, WORD_CNT}, 64'd0);
        chk("s6_rst_dout",  {62'd0, DOUT}, 64'd2);
        repeat (3) @(posedge CLKS);
        @(negedge CLKS);
        RSTXS = 1'b1;
        repeat (31) @(posedge CLKS);
        #1;
        chk("s6_frame_pre", {63'd0, FRAME}, 64'd1);
        chk("s6_wcnt_pre",  {32'd0, WORD_CNT}, 64'd0);
        chk("s6_ready_pre", {63'd0, sif.DIN_READY}, 64'd0);
        @(posedge CLKS); #1;
        chk("s6_frame_fall", {63'd0, FRAME}, 64'd0);
        chk("s6_wcnt_1",     {32'd0, WORD_CNT}, 64'd1);
        capture(-1, -1, -1, 1'b1, w, rdy);
        chk("s6_prbs0", w, prbs_word(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
